// File: rtl/cfu_mac_seq.sv
// Sequential custom-function unit: 4-lane int8 multiply-accumulate with a signed
// input offset and a 32-bit wrapping accumulator, behind a valid/ready cmd/rsp pair.
module cfu_mac_seq #(
  parameter int ACC_W = 32,
  parameter int OFF_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_payload_function_id,
  input  logic [31:0]      cmd_payload_inputs_0,
  input  logic [31:0]      cmd_payload_inputs_1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ACC_W-1:0] rsp_payload_outputs_0
);

  localparam int PROD_W = 19;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_e;

  typedef enum logic [2:0] {
    OP_SET_OFFSET = 3'd0,
    OP_CLEAR      = 3'd1,
    OP_MAC4       = 3'd2,
    OP_READ       = 3'd3
  } op_e;

  state_e                   state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [OFF_W-1:0]         offset_q, offset_d;
  logic [3:0][PROD_W-1:0]   prod_q, prod_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [ACC_W-1:0]         rsp_data_q, rsp_data_d;
  logic                     cmd_ready_q, cmd_ready_d;

  logic [3:0][PROD_W-1:0]   lane_prod;
  logic [ACC_W-1:0]         mac_sum;
  logic [2:0]               funct3;
  logic                     unused_fid;

  // A_k * (B_k + offset): 10-bit signed sum, 19-bit signed product.
  function automatic logic [PROD_W-1:0] lane_mul(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [OFF_W-1:0] off);
    logic signed [9:0]        b_w, off_w, sum;
    logic signed [PROD_W-1:0] a_w, sum_w, prod;
    b_w   = {{2{b[7]}}, b};
    off_w = {{(10-OFF_W){off[OFF_W-1]}}, off};
    sum   = b_w + off_w;
    a_w   = {{(PROD_W-8){a[7]}}, a};
    sum_w = {{(PROD_W-10){sum[9]}}, sum};
    prod  = a_w * sum_w;
    return prod;
  endfunction

  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  assign funct3     = cmd_payload_function_id[2:0];
  assign unused_fid = ^cmd_payload_function_id[9:3];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_prod[k] = lane_mul(cmd_payload_inputs_0[8*k +: 8], cmd_payload_inputs_1[8*k +: 8],
                              offset_q);
    end
  end

  assign mac_sum = acc_q + sext_prod(prod_q[0]) + sext_prod(prod_q[1])
                         + sext_prod(prod_q[2]) + sext_prod(prod_q[3]);

  always_comb begin
    // NOTE: every _d gets a hold value first so no path through the case infers a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    offset_d    = offset_q;
    prod_d      = prod_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          case (funct3)
            OP_SET_OFFSET: offset_d = cmd_payload_inputs_0[OFF_W-1:0];
            OP_CLEAR: begin
              rsp_data_d = acc_q;
              acc_d      = '0;
            end
            OP_MAC4: begin
              prod_d      = lane_prod;
              state_d     = MUL;
              rsp_valid_d = 1'b0;
            end
            OP_READ: rsp_data_d = acc_q;
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d       = mac_sum;
        rsp_data_d  = mac_sum;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  // NOTE: state flops use non-blocking assignments only; all next-state math lives above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      offset_q    <= '0;
      // NOTE: the product pipeline register is cleared too, so nothing stale survives reset.
      prod_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      offset_q    <= offset_d;
      prod_q      <= prod_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

endmodule

// File: doc/cfu_mac_seq.md
CFU_MAC_SEQ -- requirements
Module: cfu_mac_seq

Interface
REQ-001 Parameter: ACC_W, default 32, accumulator and response width; only 32 is supported.
REQ-002 Parameter: OFF_W, default 9, signed input-offset register width.
REQ-003 Port: clk, input, 1, sole clock; all state on rising edge.
REQ-004 Port: reset, input, 1, synchronous active-high reset.
REQ-005 Port: cmd_valid, input, 1, command present.
REQ-006 Port: cmd_ready, output, 1, block accepts command this cycle.
REQ-007 Port: cmd_payload_function_id, input, 10, bits [2:0] select the operation; bits [9:3] ignored.
REQ-008 Port: cmd_payload_inputs_0, input, 32, operand A: four packed signed int8 lanes (lane k = bits [8k+7:8k]).
REQ-009 Port: cmd_payload_inputs_1, input, 32, operand B: four packed signed int8 lanes.
REQ-010 Port: rsp_valid, output, 1, response present.
REQ-011 Port: rsp_ready, input, 1, consumer accepts response.
REQ-012 Port: rsp_payload_outputs_0, output, 32, response data.

Function
REQ-013 The state machine SHALL have exactly the states IDLE, MUL and RESP.
REQ-014 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-015 The block SHALL decode funct3 = function_id[2:0] as follows:
- 0 = SET_OFFSET
- 1 = CLEAR
- 2 = MAC4
- 3 = READ
- 4-7 = NOP
REQ-016 SET_OFFSET: offset <= inputs_0[OFF_W-1:0] (signed); response 0; IDLE->RESP.
REQ-017 CLEAR: response = accumulator value before the clear; accumulator <= 0; IDLE->RESP.
REQ-018 READ: response = accumulator; no state change other than IDLE->RESP.
REQ-019 NOP: response 0; offset and accumulator unchanged; IDLE->RESP.
REQ-020 MAC4, accept cycle: register the four lane products p_k = A_k * (B_k + offset) in a pipeline register; IDLE->MUL.
- Arithmetic: B_k + offset is a 10-bit signed sum; p_k is a 19-bit signed product, sign-extended.
REQ-021 MAC4, MUL cycle: accumulator <= accumulator + p_0 + p_1 + p_2 + p_3 (modulo 2^32, no saturation); response = new accumulator; MUL->RESP.
REQ-022 Latency: rsp_valid SHALL rise 1 cycle after acceptance for non-MAC operations and 2 cycles after acceptance for MAC4.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_payload_outputs_0 SHALL be held stable until rsp_valid and rsp_ready are both 1.
- On the handshake cycle the state SHALL return to IDLE.
REQ-024 rsp_valid SHALL be 0 in IDLE and MUL; rsp_payload_outputs_0 SHALL be 0 whenever rsp_valid is 0.
REQ-025 Command payloads SHALL be sampled only on the accept cycle; later changes to them while busy SHALL have no effect.
REQ-026 cmd_valid asserted outside IDLE SHALL be ignored and not queued; maximum throughput is one command per 2 cycles (non-MAC) or 3 cycles (MAC4).
REQ-027 Accumulator overflow SHALL wrap silently; there is no overflow flag.

Reset
REQ-028 While reset is 1 at a rising edge, the following SHALL hold at the next cycle:
- state = IDLE
- accumulator = 0
- offset = 0
- product pipeline register = 0
- rsp_valid = 0, rsp_payload_outputs_0 = 0, cmd_ready = 1
REQ-029 Reset asserted in MUL or RESP SHALL discard the in-flight operation; its accumulator update SHALL NOT occur.
REQ-030 Reset SHALL override a simultaneous command acceptance or response handshake.

Verification
REQ-031 Basic MAC scenario:
- Stimulus: SET_OFFSET 128 (inputs_0 = 0x080), then CLEAR, then MAC4 with A = 0x01010101, B = 0x00000000.
- Response: the MAC4 response is 512, arriving 2 cycles after acceptance.
REQ-032 Signed lanes scenario:
- Stimulus: offset 0, CLEAR, MAC4 with A = 0xFF02FF02, B = 0x03030303.
- Response: 6; a following READ returns 6.
REQ-033 Extreme operands scenario:
- Stimulus: SET_OFFSET -256 (inputs_0 = 0x100), CLEAR, MAC4 with A = 0x80808080, B = 0x80808080.
- Response: 196608.
REQ-034 Backpressure scenario:
- Stimulus: hold rsp_ready = 0 for 5 cycles after a READ while driving cmd_valid = 1.
- Response: rsp_valid stays 1 with a stable payload; cmd_ready stays 0; no second command is taken; a single handshake then follows.
REQ-035 Reset mid-operation scenario:
- Stimulus: assert reset in the MUL cycle of a MAC4 that starts from accumulator = 10.
- Response: next cycle rsp_valid = 0 and cmd_ready = 1; a subsequent READ returns 0.
REQ-036 NOP scenario:
- Stimulus: funct3 = 5 with arbitrary operands, sent after an accumulator value of 6.
- Response: response 0; a following READ still returns 6.
